// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TEST   = 2'd1,
    FINISH = 2'd2
  } sar_state_t;

  localparam int SAR_WIDTH  = 4;
  localparam int SAR_SETTLE = 0;
  localparam int SAR_CNT_W  = 3;

endpackage

// File: rtl/sar_settle_cnt.sv
// Down-counter that holds each trial word for a programmable number of extra cycles.
// Latency: load/decrement take effect on the next clock; zero is combinational from the count.
// Backpressure: none; load has priority over decrement.
module sar_settle_cnt
  import sar_pkg::*;
#(
  parameter int CW = SAR_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // Reload at the start of each bit, otherwise count down toward the sample cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sar_ctrl4.sv
// Successive-approximation controller driving an external unsigned >= comparator.
// Latency: DONE/RESULT appear WIDTH*(SETTLE+1)+1 cycles after the START edge.
// Backpressure: none; START is ignored while BUSY, so conversions never queue.
module sar_ctrl4
  import sar_pkg::*;
#(
  parameter int WIDTH  = SAR_WIDTH,
  parameter int SETTLE = SAR_SETTLE
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic             GE,
  output logic [WIDTH-1:0] TRIAL,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam logic [WIDTH-1:0]     MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SAR_CNT_W-1:0] SETTLE_V = SAR_CNT_W'(SETTLE);

  sar_state_t       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mask;
  logic             settle_load;
  logic             settle_dec;
  logic             settle_zero;
  logic             sample_now;

  // A bit is decided only once its settle window has expired.
  always_comb begin
    sample_now  = (state == TEST) && settle_zero;
    settle_load = ((state == IDLE) && START) || (sample_now && !mask[0]);
    settle_dec  = (state == TEST) && !settle_zero;
  end

  sar_settle_cnt #(
    .CW(SAR_CNT_W)
  ) u_settle (
    .clk      (CLK),
    .rst_n    (RESETN),
    .load     (settle_load),
    .load_val (SETTLE_V),
    .dec      (settle_dec),
    .zero     (settle_zero)
  );

  // Conversion sequencer: walks the mask from MSB to LSB, keeping bits the comparator accepts.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state  <= IDLE;
      acc    <= '0;
      mask   <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            acc   <= '0;
            mask  <= MSB_ONLY;
            BUSY  <= 1'b1;
            state <= TEST;
          end
        end
        TEST: begin
          if (sample_now) begin
            if (GE) begin
              acc <= acc | mask;
            end
            if (mask[0]) begin
              // RESULT takes the final bit directly so it is valid in the FINISH cycle with DONE.
              RESULT <= GE ? (acc | mask) : acc;
              DONE   <= 1'b1;
              state  <= FINISH;
            end else begin
              mask <= mask >> 1;
            end
          end
        end
        FINISH: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          mask  <= '0;
          state <= IDLE;
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign TRIAL = (state == TEST) ? (acc | mask) : '0;

endmodule

// File: tb/tb_sar_ctrl4.sv
// Bench for sar_ctrl4: two instances (SETTLE=0 and SETTLE=2), each closed through a >= comparator.
// Latency: expected trial words and results are queued from a software SAR model.
// Backpressure: START re-pulses and resets are applied mid-conversion.
module tb_sar_ctrl4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start2;
  logic [3:0] sample0, sample2;
  logic       ge0, ge2;
  logic [3:0] trial0, trial2, result0, result2;
  logic       busy0, busy2, done0, done2;

  always #5 clk = ~clk;

  assign ge0 = (sample0 >= trial0);
  assign ge2 = (sample2 >= trial2);

  sar_ctrl4 #(.WIDTH(4), .SETTLE(0)) u_d0 (
    .CLK(clk), .RESETN(rst_n), .START(start0), .GE(ge0),
    .TRIAL(trial0), .BUSY(busy0), .DONE(done0), .RESULT(result0)
  );

  sar_ctrl4 #(.WIDTH(4), .SETTLE(2)) u_d2 (
    .CLK(clk), .RESETN(rst_n), .START(start2), .GE(ge2),
    .TRIAL(trial2), .BUSY(busy2), .DONE(done2), .RESULT(result2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sel   = 0;
  int done_cyc = 0;
  int last_res [2];
  int q_trial [$];
  int q_res   [$];

  logic [3:0] trial_s, result_s;
  logic       busy_s, done_s;

  always @(posedge clk) cyc = cyc + 1;

  always_comb begin
    trial_s  = trial0;
    result_s = result0;
    busy_s   = busy0;
    done_s   = done0;
    if (sel == 1) begin
      trial_s  = trial2;
      result_s = result2;
      busy_s   = busy2;
      done_s   = done2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; raises START in the current cycle so back-to-back calls abut.
  task automatic run(input int s, input int sample, input int settle, input bit repulse);
    int acc, t, n, prev;
    sel  = s;
    prev = last_res[s];
    acc  = 0;
    for (int b = 3; b >= 0; b--) begin
      t = acc | (1 << b);
      for (int r = 0; r <= settle; r++) q_trial.push_back(t);
      if (sample >= t) acc = t;
    end
    q_res.push_back(acc);
    n = 4 * (settle + 1);
    if (s == 0) begin
      sample0 = 4'(sample);
      start0  = 1'b1;
    end else begin
      sample2 = 4'(sample);
      start2  = 1'b1;
    end
    @(posedge clk); #1;
    start0 = 1'b0;
    start2 = 1'b0;
    for (int k = 1; k <= n + 1; k++) begin
      if (k <= n) begin
        chk("trial", 32'(trial_s), q_trial.pop_front());
        chk("busy", 32'(busy_s), 1);
        chk("done_early", 32'(done_s), 0);
        chk("result_hold", 32'(result_s), prev);
      end else begin
        chk("done_pulse", 32'(done_s), 1);
        chk("result", 32'(result_s), q_res.pop_front());
        chk("trial_finish", 32'(trial_s), 0);
        chk("busy_finish", 32'(busy_s), 1);
        done_cyc = cyc;
      end
      if (s == 0) start0 = repulse && (k == 2 || k == 3);
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    chk("idle_busy", 32'(busy_s), 0);
    chk("idle_done", 32'(done_s), 0);
    chk("idle_trial", 32'(trial_s), 0);
    chk("idle_result", 32'(result_s), acc);
    last_res[s] = acc;
  endtask

  initial begin
    int first_done;
    last_res[0] = 0;
    last_res[1] = 0;
    rst_n   = 1'b0;
    start0  = 1'b0;
    start2  = 1'b0;
    sample0 = 4'd0;
    sample2 = 4'd0;
    #1;
    chk("rst_trial0", 32'(trial0), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_result0", 32'(result0), 0);
    chk("rst_trial2", 32'(trial2), 0);
    chk("rst_result2", 32'(result2), 0);
    idle(3);
    rst_n = 1'b1;

    // First edge with reset released must accept START.
    run(0, 11, 0, 1'b0);
    idle(2);
    run(0, 0, 0, 1'b0);
    idle(1);
    run(0, 15, 0, 1'b0);
    idle(1);
    run(1, 6, 2, 1'b0);
    idle(2);
    run(0, 13, 0, 1'b1);
    idle(1);

    // Reset in cycle 2 of a conversion.
    sel     = 0;
    sample0 = 4'd12;
    start0  = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("abort_c1_trial", 32'(trial0), 8);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_trial", 32'(trial0), 0);
    chk("abort_busy", 32'(busy0), 0);
    chk("abort_done", 32'(done0), 0);
    chk("abort_result", 32'(result0), 0);
    chk("abort_result2", 32'(result2), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done0), 0);
    end
    last_res[0] = 0;
    last_res[1] = 0;
    rst_n = 1'b1;
    run(0, 9, 0, 1'b0);
    idle(2);

    // Back-to-back: second START in the first idle cycle after DONE.
    run(0, 5, 0, 1'b0);
    first_done = done_cyc;
    run(0, 10, 0, 1'b0);
    chk("b2b_gap", 32'(done_cyc - first_done), 6);
    chk("queues_drained", 32'(q_trial.size() + q_res.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
